// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin decoder arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int N_DEF        = 16;
  localparam int IW_DEF       = 4;
  localparam int MAX_HOLD_DEF = 15;

endpackage

// File: rtl/arb_dec_en.sv
// Enable-gated binary-to-one-hot decoder; o_dec[k] is set only when enabled and i_idx == k.
module arb_dec_en
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [IW-1:0] i_idx,
  input  logic          i_en,
  output logic [0:N-1]  o_dec
);

  // one comparator per output line, all gated by the enable
  always_comb begin
    o_dec = '0;
    for (int k = 0; k < N; k++) begin
      o_dec[k] = i_en && (i_idx == IW'(k));
    end
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter with hold-until-release grants, a hold timeout and a decoded one-hot grant.
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IW       = IW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [N-1:0]  i_req,
  input  logic          i_done,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_idx,
  output logic [0:N-1]  o_gnt,
  output logic          o_timeout
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic          r_gnt_valid;
  logic          w_valid_nxt;
  logic [IW-1:0] r_gnt_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_timeout;
  logic          w_timeout_nxt;

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW-1:0] w_winner;
  logic          w_to_hit;
  logic          w_owner_req;

  // rotate so bit 0 of w_rot is requester r_ptr, then take the lowest set bit
  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int k = 0; k < N; k++) begin
      w_rot[k] = i_req[IW'(k) + r_ptr];
    end
    for (int k = N - 1; k >= 0; k--) begin
      w_off = w_rot[k] ? IW'(k) : w_off;
    end
  end

  assign w_winner    = r_ptr + w_off;
  assign w_owner_req = i_req[r_gnt_idx];
  assign w_to_hit    = (MAX_HOLD != 0) && (r_hold_cnt == HW'(MAX_HOLD - 1));

  // next-state and next-register values
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_valid_nxt   = r_gnt_valid;
    w_idx_nxt     = r_gnt_idx;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && (i_req != '0)) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        w_hold_nxt = (r_hold_cnt == HW'(MAX_HOLD)) ? r_hold_cnt : r_hold_cnt + HW'(1);
        if (i_done || !w_owner_req || w_to_hit) begin
          w_state_nxt   = ST_IDLE;
          w_valid_nxt   = 1'b0;
          w_ptr_nxt     = r_gnt_idx + IW'(1);
          // done and owner-drop take priority, so only a pure timeout pulses
          w_timeout_nxt = !i_done && w_owner_req && w_to_hit;
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  arb_dec_en #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .i_idx (r_gnt_idx),
    .i_en  (r_gnt_valid),
    .o_dec (o_gnt)
  );

  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed self-checking bench for rr_dec_arbiter (N=16, MAX_HOLD=15).
module tb_rr_dec_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [0:15] gnt;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  rr_dec_arbiter #(
    .N        (16),
    .IW       (4),
    .MAX_HOLD (15)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req       (req),
    .i_done      (done),
    .o_gnt_valid (gnt_valid),
    .o_gnt_idx   (gnt_idx),
    .o_gnt       (gnt),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected one-hot: index 0 is the leftmost (MSB) bit of the [0:15] vector
  task automatic check_out(input string tag, input logic v, input logic [3:0] idx, input logic to);
    logic [15:0] exp_gnt;
    exp_gnt = v ? (16'h8000 >> idx) : 16'h0000;
    check({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, v});
    if (v) check({tag, ".idx"}, {28'd0, gnt_idx}, {28'd0, idx});
    check({tag, ".gnt"}, {16'd0, gnt}, {16'd0, exp_gnt});
    check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 16'hFFFF; done = 1'b0;
    #1;
    // reset with all requests pending
    tick(2);
    check_out("reset", 1'b0, 4'd0, 1'b0);
    check("reset.idx", {28'd0, gnt_idx}, 32'd0);
    rst = 1'b0;
    tick(1);
    check_out("first_grant", 1'b1, 4'd0, 1'b0);

    // full round robin with done one cycle after each grant
    for (int i = 1; i <= 16; i++) begin
      done = 1'b1;
      tick(1);
      check_out($sformatf("rr_dead%0d", i), 1'b0, 4'd0, 1'b0);
      done = 1'b0;
      tick(1);
      check_out($sformatf("rr_gnt%0d", i), 1'b1, 4'(i % 16), 1'b0);
    end

    // wrap and skip: owner 0, req bits 0 and 14
    req = 16'h4001;
    done = 1'b1; tick(1);
    check_out("ws_rel0", 1'b0, 4'd0, 1'b0);
    done = 1'b0; tick(1);
    check_out("ws_gnt14", 1'b1, 4'd14, 1'b0);
    done = 1'b1; tick(1);
    check_out("ws_rel14", 1'b0, 4'd0, 1'b0);
    done = 1'b0; tick(1);
    check_out("ws_gnt0", 1'b1, 4'd0, 1'b0);
    req = 16'h0003;
    done = 1'b1; tick(1);
    done = 1'b0; tick(1);
    check_out("ws_ptr1", 1'b1, 4'd1, 1'b0);

    // owner drops its request: release without timeout, then grant 5
    req = 16'h0020;
    tick(1);
    check_out("drop_rel", 1'b0, 4'd0, 1'b0);
    tick(1);
    check_out("to_gnt5", 1'b1, 4'd5, 1'b0);
    for (int c = 2; c <= 15; c++) begin
      tick(1);
      check_out($sformatf("to_hold%0d", c), 1'b1, 4'd5, 1'b0);
    end
    tick(1);
    check_out("to_release", 1'b0, 4'd0, 1'b1);
    tick(1);
    check_out("to_regrant5", 1'b1, 4'd5, 1'b0);

    // done coincides with the timeout cycle: release, no timeout pulse
    tick(14);
    check_out("dt_cycle15", 1'b1, 4'd5, 1'b0);
    done = 1'b1; tick(1);
    check_out("dt_release", 1'b0, 4'd0, 1'b0);
    done = 1'b0;

    // enable dropped during a grant to 3
    req = 16'h0008;
    tick(1);
    check_out("en_gnt3", 1'b1, 4'd3, 1'b0);
    en = 1'b0; req = 16'hFFFF;
    tick(1);
    check_out("en_hold3", 1'b1, 4'd3, 1'b0);
    done = 1'b1; tick(1);
    check_out("en_rel3", 1'b0, 4'd0, 1'b0);
    done = 1'b0; tick(2);
    check_out("en_blocked", 1'b0, 4'd0, 1'b0);
    check("en_blocked.idx_kept", {28'd0, gnt_idx}, 32'd3);
    en = 1'b1; tick(1);
    check_out("en_gnt4", 1'b1, 4'd4, 1'b0);

    // reset mid-grant with a simultaneous done
    rst = 1'b1; done = 1'b1; tick(1);
    check_out("mid_rst", 1'b0, 4'd0, 1'b0);
    check("mid_rst.idx", {28'd0, gnt_idx}, 32'd0);
    rst = 1'b0; done = 1'b0; tick(1);
    check_out("post_rst_gnt0", 1'b1, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_dec_arbiter.md
# rr_dec_arbiter

Round-robin arbiter that shares one downstream resource among `N` requesters. It issues a registered binary grant index and a one-hot grant vector. The one-hot vector comes from an enable-gated binary-to-one-hot decoder driven by that index. The arbiter holds each grant until the owner signals `done`, the owner drops its request, or a hold timeout expires. It sits in front of any decoder-selected shared resource (bus, chip-selects, shared register bank) and is the sequencing layer above the team's enable decoders.

## Interface
- `N`, 16: number of requesters; power of two, 2..16.
- `IW`, 4: index width; must equal log2(`N`).
- `MAX_HOLD`, 15: maximum grant length in cycles; 0 disables the timeout.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arbitration enable; gates only the issue of new grants.
- `req`  in  N  request vector; bit k belongs to requester k.
- `done`  in  1  current owner releases the grant.
- `gnt_valid`  out  1  a grant is active.
- `gnt_idx`  out  IW  binary index of the owner.
- `gnt`  out  [0:N-1]  one-hot grant; `gnt[k]`=1 iff `gnt_valid` and `gnt_idx`==k.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- FSM states:
  - IDLE: no grant active.
  - GRANT: grant active and held.
- IDLE → GRANT when `en`=1 and `req`≠0.
  - Winner is the first set bit of `req` at or after `ptr`, searching upward with wrap-around modulo `N`.
  - Register `gnt_idx`=winner and `gnt_valid`=1, and clear `hold_cnt`.
- IDLE with `en`=0 or `req`=0: stay in IDLE; outputs hold their reset values except `gnt_idx`, which keeps its last value.
- GRANT: `hold_cnt` increments each cycle, saturating at `MAX_HOLD`.
- GRANT → IDLE (release) on the first of these, in priority order:
  1. `done`=1.
  2. `req[gnt_idx]`=0.
  3. `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`-1. This case also asserts `timeout` for one cycle, registered with the release.
- On release:
  - `ptr` ← `gnt_idx`+1 mod `N`.
  - `gnt_valid` ← 0.
  - The next arbitration happens in the following IDLE cycle, so there is always one dead cycle between grants.
- `en` going low during GRANT does not revoke the grant. It only blocks the next one.
- `done` in IDLE is ignored.
- If `done` and the timeout condition occur in the same cycle, `timeout` stays 0.
- `gnt` is combinational from the registered `gnt_idx` and `gnt_valid` only, so it is glitch-free relative to `clk`.

## Timing
- Reset values: state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt_valid`=0, `gnt_idx`=0, `gnt`=all zeros, `timeout`=0.
- Grant latency:
  - `req` sampled at edge t in IDLE → `gnt_valid`/`gnt_idx`/`gnt` valid after edge t+1.
- Release latency:
  - `done` sampled at edge t → `gnt_valid`=0 after edge t+1.
  - The earliest following grant is after edge t+2.
- Grant length with timeout: exactly `MAX_HOLD` cycles of `gnt_valid`=1. `timeout` is high in the first cycle after release.
- Wrap-around: with `ptr`=N-1 and only `req[0]` set, the grant goes to 0 and `ptr` becomes 1 on release.
- Reset mid-grant: the cycle after the `rst` edge, all outputs are at reset values. Any `done` sampled alongside `rst` is ignored.
- Maximum throughput: one grant per 2 cycles (1-cycle hold plus 1 dead cycle).

## Structure
- Shared package `arb_pkg`: state enum (`ST_IDLE`, `ST_GRANT`) and default constants for `N`, `IW` and `MAX_HOLD`.
- One sub-module, `arb_dec_en`:
  - Parameterised enable decoder; `IW`-bit input plus enable in, `[0:N-1]` one-hot out.
  - All-zero output when the enable is low.
  - Instantiated once with enable=`gnt_valid`.
- Top level contains:
  - FSM.
  - `ptr` register.
  - `hold_cnt`.
  - Rotate-priority search (rotate `req` by `ptr`, priority-encode, add `ptr` back modulo `N`).

## Test plan
- Reset check: assert `rst` for 2 cycles with `req`=16'hFFFF → all outputs zero. After release of `rst`, first grant `gnt_idx`=0 and `gnt`=16'h8000 (bit 0 first), one cycle after the first sampled edge.
- Round robin: `req`=16'hFFFF held, `done` pulsed one cycle after each grant → `gnt_idx` sequence 0,1,2,…,15,0 with one dead cycle between grants.
- Wrap and skip: grant 14 with `req`=16'h4001 (bits 0 and 14), then `done` → next grant 0, not 14; `ptr` becomes 1.
- Timeout: `MAX_HOLD`=15, `req[5]` held, `done` never asserted → `gnt_valid` high for exactly 15 cycles, `timeout` pulses once, next grant goes to another requester if present, otherwise 5 again.
- Simultaneous `done` and timeout on cycle 15 → release occurs and `timeout` stays 0.
- Enable and reset mid-operation: drop `en` during a grant to 3 → grant persists until `done`, then no new grant while `en`=0. Raise `en` → grant resumes from `ptr`=4. Assert `rst` during an active grant → outputs zero next cycle and the next grant search starts from 0.
